// File: rtl/jtag_dr_ir_regs_if.sv
// TAP-side strobes, serial data and debug bus of the JTAG IR/DR register bank.
// The master is the TAP/debug host side; the slave is the register bank.
interface jtag_dr_ir_regs_if #(
  parameter int IR_W = 4
);
  logic            tdi;
  logic            tdo;
  logic            mode;
  logic            shift_dr;
  logic            clk_dr;
  logic            update_dr;
  logic            shift_ir;
  logic            clk_ir;
  logic            update_ir;
  logic            sel_tdo;
  logic [IR_W-1:0] ir_out;
  logic [31:0]     dbg_addr;
  logic [31:0]     dbg_wdata;
  logic            dbg_we;
  logic [31:0]     dbg_rdata;

  modport master (
    output tdi, mode, shift_dr, clk_dr, update_dr, shift_ir, clk_ir, update_ir,
           sel_tdo, dbg_rdata,
    input  tdo, ir_out, dbg_addr, dbg_wdata, dbg_we
  );

  modport slave (
    input  tdi, mode, shift_dr, clk_dr, update_dr, shift_ir, clk_ir, update_ir,
           sel_tdo, dbg_rdata,
    output tdo, ir_out, dbg_addr, dbg_wdata, dbg_we
  );
endinterface

// File: rtl/jtag_dr_ir_regs.sv
// JTAG instruction register plus IDCODE / DBG_ADDR / DBG_DATA / BYPASS data
// registers, driving a 32-bit debug address/write-data port.
module jtag_dr_ir_regs #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter bit          AUTO_INC   = 1'b1
) (
  input logic               i_tck,
  input logic               i_trst,
  jtag_dr_ir_regs_if.slave  bus
);
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_ADDR    = IR_W'(2);
  localparam logic [IR_W-1:0] IR_DATA    = IR_W'(3);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

  logic [IR_W-1:0] r_ir_sh;
  logic [IR_W-1:0] r_ir_out;
  logic [31:0]     r_dr_sh [3];
  logic            r_bypass;
  logic [31:0]     r_dbg_addr;
  logic [31:0]     r_dbg_wdata;
  logic            r_dbg_we;
  logic            r_upd_dly;

  logic            w_ir_cap, w_ir_shf, w_ir_upd;
  logic            w_dr_cap, w_dr_shf, w_dr_upd_rise;
  logic [2:0]      w_sel;
  logic            w_sel_bypass;
  logic [31:0]     w_cap_val [3];
  logic            w_dr_tdo;

  // Shift is excluded from capture so shift wins when both are decoded.
  assign w_ir_cap      = bus.clk_ir & ~bus.shift_ir;
  assign w_ir_shf      = bus.shift_ir;
  assign w_ir_upd      = bus.update_ir;
  assign w_dr_cap      = bus.clk_dr & ~bus.shift_dr;
  assign w_dr_shf      = bus.shift_dr;
  assign w_dr_upd_rise = bus.update_dr & ~r_upd_dly;

  // Index 0 = IDCODE, 1 = DBG_ADDR, 2 = DBG_DATA; anything else is BYPASS.
  assign w_sel        = {r_ir_out == IR_DATA, r_ir_out == IR_ADDR, r_ir_out == IR_IDCODE};
  assign w_sel_bypass = ~|w_sel;
  assign w_cap_val[0] = IDCODE_VAL;
  assign w_cap_val[1] = r_dbg_addr;
  assign w_cap_val[2] = bus.dbg_rdata;

  always_ff @(posedge i_tck) begin
    if (i_trst || !bus.mode) begin
      r_ir_sh  <= '0;
      r_ir_out <= IR_IDCODE;
    end else begin
      if (w_ir_shf)
        r_ir_sh <= {bus.tdi, r_ir_sh[IR_W-1:1]};
      else if (w_ir_cap)
        r_ir_sh <= IR_CAPTURE;
      if (w_ir_upd)
        r_ir_out <= r_ir_sh;
    end
  end

  always_ff @(posedge i_tck) begin
    if (i_trst) begin
      for (int i = 0; i < 3; i++)
        r_dr_sh[i] <= '0;
      r_bypass <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_sel[i] && w_dr_shf)
          r_dr_sh[i] <= {bus.tdi, r_dr_sh[i][31:1]};
        else if (w_sel[i] && w_dr_cap)
          r_dr_sh[i] <= w_cap_val[i];
      end
      if (w_sel_bypass && w_dr_shf)
        r_bypass <= bus.tdi;
      else if (w_sel_bypass && w_dr_cap)
        r_bypass <= 1'b0;
    end
  end

  // The write pulse carries the old address; auto-increment lands after it.
  always_ff @(posedge i_tck) begin
    if (i_trst) begin
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
      r_dbg_we    <= 1'b0;
      r_upd_dly   <= 1'b0;
    end else begin
      r_upd_dly <= bus.update_dr;
      r_dbg_we  <= w_dr_upd_rise & w_sel[2];
      if (w_dr_upd_rise && w_sel[2])
        r_dbg_wdata <= r_dr_sh[2];
      if (w_dr_upd_rise && w_sel[1])
        r_dbg_addr <= r_dr_sh[1];
      else if (AUTO_INC && r_dbg_we)
        r_dbg_addr <= r_dbg_addr + 32'd4;
    end
  end

  always_comb begin
    w_dr_tdo = r_bypass;
    for (int i = 0; i < 3; i++)
      if (w_sel[i])
        w_dr_tdo = r_dr_sh[i][0];
  end

  assign bus.tdo       = (bus.shift_ir | bus.shift_dr) ?
                         (bus.sel_tdo ? r_ir_sh[0] : w_dr_tdo) : 1'b0;
  assign bus.ir_out    = r_ir_out;
  assign bus.dbg_addr  = r_dbg_addr;
  assign bus.dbg_wdata = r_dbg_wdata;
  assign bus.dbg_we    = r_dbg_we;
endmodule

// File: tb/tb_jtag_dr_ir_regs.sv
// Randomised bench for jtag_dr_ir_regs: drives TAP strobe sequences and checks
// TDO streams and the debug port against a register-level reference model.
module tb_jtag_dr_ir_regs;
  localparam int          IR_W   = 4;
  localparam logic [31:0] IDCODE = 32'h1000_0001;

  logic tck = 1'b0;
  logic trst;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [IR_W-1:0] m_ir;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [63:0]     we_q[$];

  jtag_dr_ir_regs_if #(.IR_W(IR_W)) bus ();

  jtag_dr_ir_regs #(.IR_W(IR_W), .IDCODE_VAL(IDCODE), .AUTO_INC(1'b1)) dut (
    .i_tck  (tck),
    .i_trst (trst),
    .bus    (bus)
  );

  always #5 tck = ~tck;

  always @(negedge tck)
    if (bus.dbg_we === 1'b1)
      we_q.push_back({bus.dbg_addr, bus.dbg_wdata});

  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, input bit upd,
                         output logic [31:0] dout);
    dout = '0;
    bus.sel_tdo = 1'b0;
    bus.clk_dr = 1'b1; bus.shift_dr = 1'b0; cyc();
    bus.shift_dr = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.tdi = din[i];
      @(negedge tck);
      dout[i] = bus.tdo;
      cyc();
    end
    bus.shift_dr = 1'b0; bus.clk_dr = 1'b0; bus.tdi = 1'b0;
    if (upd) begin
      bus.update_dr = 1'b1; cyc(); bus.update_dr = 1'b0;
    end
    idle(2);
  endtask

  task automatic ir_scan(input logic [IR_W-1:0] v, output logic [IR_W-1:0] cap);
    cap = '0;
    bus.sel_tdo = 1'b1;
    bus.clk_ir = 1'b1; bus.shift_ir = 1'b0; cyc();
    bus.shift_ir = 1'b1;
    for (int i = 0; i < IR_W; i++) begin
      bus.tdi = v[i];
      @(negedge tck);
      cap[i] = bus.tdo;
      cyc();
    end
    bus.shift_ir = 1'b0; bus.clk_ir = 1'b0; bus.tdi = 1'b0;
    bus.update_ir = 1'b1; cyc(); bus.update_ir = 1'b0;
    bus.sel_tdo = 1'b0;
    idle(1);
    m_ir = v;
  endtask

  task automatic test_reset();
    trst = 1'b1;
    bus.mode = 1'($urandom); bus.tdi = 1'($urandom);
    bus.shift_ir = 1'($urandom); bus.clk_ir = 1'($urandom); bus.update_ir = 1'($urandom);
    bus.shift_dr = 1'($urandom); bus.clk_dr = 1'($urandom); bus.update_dr = 1'($urandom);
    idle(2);
    @(negedge tck);
    n_cmp++;
    if (bus.ir_out !== IR_W'(1)) begin
      n_err++; $display("FAIL reset_ir_out: got %h want %h", bus.ir_out, IR_W'(1));
    end
    n_cmp++;
    if (bus.dbg_we !== 1'b0) begin
      n_err++; $display("FAIL reset_we: got %b want 0", bus.dbg_we);
    end
    cyc();
    trst = 1'b0; bus.mode = 1'b1; bus.tdi = 1'b0; bus.sel_tdo = 1'($urandom);
    bus.shift_ir = 1'b0; bus.clk_ir = 1'b0; bus.update_ir = 1'b0;
    bus.shift_dr = 1'b0; bus.clk_dr = 1'b0; bus.update_dr = 1'b0;
    @(negedge tck);
    n_cmp++;
    if (bus.dbg_addr !== 32'h0 || bus.dbg_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_dbg: got addr %h wdata %h want 0 0", bus.dbg_addr, bus.dbg_wdata);
    end
    n_cmp++;
    if (bus.tdo !== 1'b0) begin
      n_err++; $display("FAIL reset_tdo_idle: got %b want 0", bus.tdo);
    end
    cyc();
    m_ir = IR_W'(1); m_addr = '0; m_wdata = '0;
    $display("reset: ir_out=%h addr=%h", bus.ir_out, bus.dbg_addr);
  endtask

  task automatic test_idcode();
    logic [31:0] dout;
    dr_scan(32, 32'h0, 1'b1, dout);
    n_cmp++;
    if (dout !== IDCODE || dout[0] !== 1'b1) begin
      n_err++; $display("FAIL idcode_scan: got %h want %h", dout, IDCODE);
    end
    $display("idcode scan: tdo=%h", dout);
  endtask

  task automatic set_ir(input logic [IR_W-1:0] v);
    logic [IR_W-1:0] cap;
    ir_scan(v, cap);
    n_cmp++;
    if (cap !== IR_W'(2'b01)) begin
      n_err++; $display("FAIL ir_capture: got %b want %b", cap, IR_W'(2'b01));
    end
    n_cmp++;
    if (bus.ir_out !== v) begin
      n_err++; $display("FAIL ir_update: got %h want %h", bus.ir_out, v);
    end
    $display("ir scan: in=%h captured=%b ir_out=%h", v, cap, bus.ir_out);
  endtask

  task automatic test_addr(input logic [31:0] a);
    logic [31:0] dout;
    if (m_ir != IR_W'(2)) set_ir(IR_W'(2));
    we_q.delete();
    dr_scan(32, a, 1'b1, dout);
    n_cmp++;
    if (dout !== m_addr) begin
      n_err++; $display("FAIL addr_capture: got %h want %h", dout, m_addr);
    end
    m_addr = a;
    n_cmp++;
    if (bus.dbg_addr !== m_addr || we_q.size() != 0) begin
      n_err++; $display("FAIL addr_update: got %h (%0d pulses) want %h (0 pulses)",
                        bus.dbg_addr, we_q.size(), m_addr);
    end
    $display("addr write: %h", a);
  endtask

  task automatic test_data(input logic [31:0] din, input logic [31:0] rdata);
    logic [31:0] dout;
    logic [63:0] p;
    if (m_ir != IR_W'(3)) set_ir(IR_W'(3));
    bus.dbg_rdata = rdata;
    we_q.delete();
    dr_scan(32, din, 1'b1, dout);
    n_cmp++;
    if (dout !== rdata) begin
      n_err++; $display("FAIL data_capture: got %h want %h", dout, rdata);
    end
    n_cmp++;
    if (we_q.size() != 1) begin
      n_err++; $display("FAIL data_pulse_count: got %0d want 1", we_q.size());
    end else begin
      p = we_q[0];
      n_cmp++;
      if (p[63:32] !== m_addr || p[31:0] !== din) begin
        n_err++; $display("FAIL data_pulse: got addr %h wdata %h want %h %h",
                          p[63:32], p[31:0], m_addr, din);
      end
    end
    m_addr = m_addr + 32'd4; m_wdata = din;
    n_cmp++;
    if (bus.dbg_addr !== m_addr || bus.dbg_wdata !== m_wdata) begin
      n_err++; $display("FAIL data_post: got addr %h wdata %h want %h %h",
                        bus.dbg_addr, bus.dbg_wdata, m_addr, m_wdata);
    end
    $display("data write: wdata=%h rdata=%h addr_now=%h", din, dout, bus.dbg_addr);
  endtask

  task automatic test_bypass(input logic [IR_W-1:0] code, input logic [7:0] pat);
    logic [31:0] dout;
    logic [7:0]  want;
    set_ir(code);
    we_q.delete();
    dr_scan(8, {24'h0, pat}, 1'b1, dout);
    want = {pat[6:0], 1'b0};
    n_cmp++;
    if (dout[7:0] !== want || we_q.size() != 0 || bus.dbg_addr !== m_addr) begin
      n_err++; $display("FAIL bypass: got %b (%0d pulses, addr %h) want %b (0, %h)",
                        dout[7:0], we_q.size(), bus.dbg_addr, want, m_addr);
    end
    $display("bypass ir=%h: in=%b out=%b", code, pat, dout[7:0]);
  endtask

  task automatic test_back_to_back();
    logic [31:0] dout;
    logic [31:0] din;
    din = $urandom;
    if (m_ir != IR_W'(3)) set_ir(IR_W'(3));
    dr_scan(32, din, 1'b0, dout);
    we_q.delete();
    bus.update_dr = 1'b1; idle(2); bus.update_dr = 1'b0;
    idle(3);
    n_cmp++;
    if (we_q.size() != 1) begin
      n_err++; $display("FAIL back_to_back_pulses: got %0d want 1", we_q.size());
    end
    m_addr = m_addr + 32'd4; m_wdata = din;
    n_cmp++;
    if (bus.dbg_addr !== m_addr || bus.dbg_wdata !== m_wdata) begin
      n_err++; $display("FAIL back_to_back_regs: got %h %h want %h %h",
                        bus.dbg_addr, bus.dbg_wdata, m_addr, m_wdata);
    end
    $display("held update: pulses=%0d addr=%h", we_q.size(), bus.dbg_addr);
  endtask

  task automatic test_mode();
    logic [IR_W-1:0] v;
    v = IR_W'(2);
    bus.sel_tdo = 1'b1;
    bus.clk_ir = 1'b1; cyc();
    bus.shift_ir = 1'b1;
    for (int i = 0; i < IR_W; i++) begin bus.tdi = v[i]; cyc(); end
    bus.shift_ir = 1'b0; bus.clk_ir = 1'b0; bus.tdi = 1'b0;
    bus.mode = 1'b0; bus.update_ir = 1'b1; cyc();
    bus.mode = 1'b1; bus.update_ir = 1'b0; bus.sel_tdo = 1'b0;
    idle(1);
    m_ir = IR_W'(1);
    n_cmp++;
    if (bus.ir_out !== m_ir || bus.dbg_addr !== m_addr || bus.dbg_wdata !== m_wdata) begin
      n_err++; $display("FAIL mode_override: got ir %h addr %h wdata %h want %h %h %h",
                        bus.ir_out, bus.dbg_addr, bus.dbg_wdata, m_ir, m_addr, m_wdata);
    end
    $display("mode=0 during ir update: ir_out=%h", bus.ir_out);
  endtask

  task automatic test_trst_mid();
    if (m_ir != IR_W'(3)) set_ir(IR_W'(3));
    we_q.delete();
    bus.clk_dr = 1'b1; cyc();
    bus.shift_dr = 1'b1;
    for (int i = 0; i < 10; i++) begin bus.tdi = 1'($urandom); cyc(); end
    trst = 1'b1; bus.update_dr = 1'b1; cyc();
    trst = 1'b0; bus.update_dr = 1'b0; bus.shift_dr = 1'b0; bus.clk_dr = 1'b0;
    idle(3);
    m_ir = IR_W'(1); m_addr = '0; m_wdata = '0;
    n_cmp++;
    if (we_q.size() != 0) begin
      n_err++; $display("FAIL trst_mid_pulse: got %0d pulses want 0", we_q.size());
    end
    n_cmp++;
    if (bus.ir_out !== m_ir || bus.dbg_addr !== 32'h0 || bus.dbg_wdata !== 32'h0) begin
      n_err++; $display("FAIL trst_mid_regs: got ir %h addr %h wdata %h want %h 0 0",
                        bus.ir_out, bus.dbg_addr, bus.dbg_wdata, m_ir);
    end
    $display("trst mid-shift: ir_out=%h addr=%h", bus.ir_out, bus.dbg_addr);
  endtask

  initial begin
    trst = 1'b1;
    bus.dbg_rdata = '0; bus.sel_tdo = 1'b0;
    test_reset();
    test_idcode();
    test_addr(32'h0000_0100);
    test_data(32'hDEAD_BEEF, $urandom);
    test_data($urandom, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      test_addr({$urandom} & 32'hFFFF_FFFC);
      test_data($urandom, $urandom);
    end
    test_addr(32'hFFFF_FFFC);
    test_data($urandom, $urandom);
    test_bypass(IR_W'(4'hF), 8'b1011_0011);
    for (int k = 0; k < 3; k++)
      test_bypass(IR_W'($urandom_range(4, 14)), 8'($urandom));
    test_bypass(IR_W'(0), 8'($urandom));
    test_back_to_back();
    test_mode();
    test_idcode();
    test_trst_mid();
    test_idcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
